// File: rtl/sirv_gnrl_skid_buf_pkg.sv
// Shared encodings and defaults for the two-entry valid/ready skid buffer.
// The state word is {skid_vld, main_vld}; the encoding 2'b10 is never legal.
package sirv_gnrl_skid_buf_pkg;

    localparam int SKB_DW_DEF = 32;

    typedef enum logic [1:0] {
        SKB_EMPTY = 2'b00,
        SKB_ONE   = 2'b01,
        SKB_FULL  = 2'b11
    } skb_state_e;

endpackage

// File: rtl/sirv_gnrl_skid_buf_if.sv
// Valid/ready/payload channel used on both sides of the skid buffer.
// The master drives valid and data; the slave answers with ready.
interface sirv_gnrl_skid_buf_if
    import sirv_gnrl_skid_buf_pkg::*;
#(
    parameter int DW = SKB_DW_DEF
);

    logic          vld;
    logic          rdy;
    logic [DW-1:0] dat;

    modport master (
        output vld,
        output dat,
        input  rdy
    );

    modport slave (
        input  vld,
        input  dat,
        output rdy
    );

endinterface

// File: rtl/sirv_gnrl_skid_buf_dffl.sv
// Load-enabled data flop without reset; holds its value whenever lden is low.
module sirv_gnrl_dffl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Capture the next value only on an enabled cycle.
    always_ff @(posedge clk) begin
        if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_gnrl_skid_buf.sv
// Two-entry skid buffer: upstream ready comes straight from a flop so the
// downstream ready never reaches it combinationally, yet one beat per cycle flows.
module sirv_gnrl_skid_buf
    import sirv_gnrl_skid_buf_pkg::*;
#(
    parameter int DW = SKB_DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    sirv_gnrl_skid_buf_if.slave   i_ch,
    sirv_gnrl_skid_buf_if.master  o_ch,
    output logic                  o_busy
);

    skb_state_e    state_r;
    skb_state_e    state_nxt_s;

    logic          main_vld_s;
    logic          skid_vld_s;
    logic          i_rdy_s;
    logic          main_lden_s;
    logic          skid_lden_s;
    logic [DW-1:0] main_dnxt_s;
    logic [DW-1:0] main_dat_r;
    logic [DW-1:0] skid_dat_r;

    // Valid flags live in the state register; reset empties both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SKB_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Occupancy transitions; FULL ignores i_vld because i_rdy is low there.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SKB_EMPTY: begin
                if (i_ch.vld) begin
                    state_nxt_s = SKB_ONE;
                end else begin
                    state_nxt_s = SKB_EMPTY;
                end
            end
            SKB_ONE: begin
                if (i_ch.vld && !o_ch.rdy) begin
                    state_nxt_s = SKB_FULL;
                end else if (!i_ch.vld && o_ch.rdy) begin
                    state_nxt_s = SKB_EMPTY;
                end else begin
                    state_nxt_s = SKB_ONE;
                end
            end
            SKB_FULL: begin
                if (o_ch.rdy) begin
                    state_nxt_s = SKB_ONE;
                end else begin
                    state_nxt_s = SKB_FULL;
                end
            end
            default: begin
                state_nxt_s = SKB_EMPTY;
            end
        endcase
    end

    // Decode flags and the data-register load enables from the current state.
    always_comb begin
        skid_vld_s  = state_r[1];
        main_vld_s  = state_r[0];
        i_rdy_s     = ~state_r[1];
        main_lden_s = (~main_vld_s | o_ch.rdy) & (skid_vld_s | i_ch.vld);
        skid_lden_s = i_ch.vld & i_rdy_s & main_vld_s & ~o_ch.rdy;
        if (skid_vld_s) begin
            main_dnxt_s = skid_dat_r;
        end else begin
            main_dnxt_s = i_ch.dat;
        end
    end

    sirv_gnrl_dffl #(.DW(DW)) u_main_dat (
        .clk  (clk),
        .lden (main_lden_s),
        .dnxt (main_dnxt_s),
        .qout (main_dat_r)
    );

    // The skid entry is only ever fed from upstream, never from main.
    sirv_gnrl_dffl #(.DW(DW)) u_skid_dat (
        .clk  (clk),
        .lden (skid_lden_s),
        .dnxt (i_ch.dat),
        .qout (skid_dat_r)
    );

    assign i_ch.rdy = i_rdy_s;
    assign o_ch.vld = main_vld_s;
    assign o_ch.dat = main_dat_r;
    assign o_busy   = main_vld_s;

endmodule

// File: tb/tb_sirv_gnrl_skid_buf.sv
// Bench for sirv_gnrl_skid_buf: directed scenarios plus a long random run
// checked against a depth-2 FIFO model (ready = not full, valid = not empty).
module tb_sirv_gnrl_skid_buf;

    localparam int DW = 32;

    logic clk;
    logic rst;
    logic o_busy;

    int total;
    int bad;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] dut_log[$];

    sirv_gnrl_skid_buf_if #(.DW(DW)) up_if ();
    sirv_gnrl_skid_buf_if #(.DW(DW)) dn_if ();

    sirv_gnrl_skid_buf #(.DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_ch   (up_if.slave),
        .o_ch   (dn_if.master),
        .o_busy (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic iv, input logic [DW-1:0] id, input logic ordy);
        rst       = r;
        up_if.vld = iv;
        up_if.dat = id;
        dn_if.rdy = ordy;
    endtask

    // Advance one clock from a negedge to the next; updates the model and the DUT output log.
    task automatic step();
        logic pop;
        logic push;
        pop  = !rst && (mq.size() > 0) && dn_if.rdy;
        push = !rst && up_if.vld && (mq.size() < 2);
        if (!rst && dn_if.vld === 1'b1 && dn_if.rdy) dut_log.push_back(dn_if.dat);
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(up_if.dat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 32'hDEAD, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (dn_if.vld !== 1'b0) begin bad++; $display("FAIL reset_ovld cyc=%0d got=%b want=0", i, dn_if.vld); end
            total++;
            if (up_if.rdy !== 1'b1) begin bad++; $display("FAIL reset_irdy cyc=%0d got=%b want=1", i, up_if.rdy); end
            total++;
            if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", i, o_busy); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (dn_if.vld !== 1'b0) begin bad++; $display("FAIL reset_release_ovld cyc=%0d got=%b want=0", i, dn_if.vld); end
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, DW'(i), 1'b1);
            step();
            total++;
            if (dn_if.vld !== 1'b1 || dn_if.dat !== DW'(i)) begin
                bad++; $display("FAIL stream_out beat=%0d got vld=%b dat=%0d want vld=1 dat=%0d", i, dn_if.vld, dn_if.dat, i);
            end
            total++;
            if (up_if.rdy !== 1'b1) begin bad++; $display("FAIL stream_irdy beat=%0d got=%b want=1", i, up_if.rdy); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        total++;
        if (dn_if.vld !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", dn_if.vld); end
    endtask

    task automatic test_skid();
        drive(1'b0, 1'b1, 32'd1, 1'b1);
        step();
        drive(1'b0, 1'b1, 32'd2, 1'b0);
        step();
        total++;
        if (up_if.rdy !== 1'b0 || dn_if.vld !== 1'b1 || dn_if.dat !== 32'd1 || o_busy !== 1'b1) begin
            bad++; $display("FAIL skid_full got irdy=%b vld=%b dat=%0d busy=%b want irdy=0 vld=1 dat=1 busy=1", up_if.rdy, dn_if.vld, dn_if.dat, o_busy);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        total++;
        if (dn_if.dat !== 32'd1 || up_if.rdy !== 1'b0) begin
            bad++; $display("FAIL skid_hold got dat=%0d irdy=%b want dat=1 irdy=0", dn_if.dat, up_if.rdy);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        total++;
        if (dn_if.vld !== 1'b1 || dn_if.dat !== 32'd2 || up_if.rdy !== 1'b1) begin
            bad++; $display("FAIL skid_release got vld=%b dat=%0d irdy=%b want vld=1 dat=2 irdy=1", dn_if.vld, dn_if.dat, up_if.rdy);
        end
        step();
        total++;
        if (dn_if.vld !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b want=0", dn_if.vld); end
    endtask

    task automatic test_backpressure();
        int base;
        base = dut_log.size();
        drive(1'b0, 1'b1, 32'd1, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'd2, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (up_if.rdy !== 1'b0 || dn_if.dat !== 32'd1) begin
                bad++; $display("FAIL bp_stall cyc=%0d got irdy=%b dat=%0d want irdy=0 dat=1", i, up_if.rdy, dn_if.dat);
            end
        end
        drive(1'b0, 1'b1, 32'd3, 1'b1);
        step();
        total++;
        if (dn_if.dat !== 32'd2 || up_if.rdy !== 1'b1) begin
            bad++; $display("FAIL bp_second got dat=%0d irdy=%b want dat=2 irdy=1", dn_if.dat, up_if.rdy);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        total++;
        if (dn_if.vld !== 1'b1 || dn_if.dat !== 32'd3) begin
            bad++; $display("FAIL bp_third got vld=%b dat=%0d want vld=1 dat=3", dn_if.vld, dn_if.dat);
        end
        step();
        step();
        total++;
        if (dut_log.size() - base != 3 || dut_log[base] !== 32'd1 || dut_log[base+1] !== 32'd2 || dut_log[base+2] !== 32'd3) begin
            bad++; $display("FAIL bp_order got count=%0d want count=3 order 1,2,3", dut_log.size() - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        drive(1'b0, 1'b1, 32'd5, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'd6, 1'b0);
        step();
        base = dut_log.size();
        drive(1'b1, 1'b1, 32'd7, 1'b0);
        step();
        total++;
        if (dn_if.vld !== 1'b0 || up_if.rdy !== 1'b1) begin
            bad++; $display("FAIL rstmid_state got vld=%b irdy=%b want vld=0 irdy=1", dn_if.vld, up_if.rdy);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        total++;
        if (dut_log.size() != base || dn_if.vld !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_emit got emitted=%0d vld=%b want emitted=0 vld=0", dut_log.size() - base, dn_if.vld);
        end
    endtask

    task automatic test_random();
        logic          stall;
        logic [DW-1:0] held;
        logic          exp_vld;
        logic          exp_rdy;
        for (int i = 0; i < 10000; i++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
            stall = (dn_if.vld === 1'b1) && !dn_if.rdy;
            held  = dn_if.dat;
            step();
            exp_vld = (mq.size() > 0);
            exp_rdy = (mq.size() < 2);
            total++;
            if (dn_if.vld !== exp_vld || o_busy !== exp_vld) begin
                bad++; $display("FAIL rand_vld cyc=%0d got vld=%b busy=%b want=%b", i, dn_if.vld, o_busy, exp_vld);
            end
            total++;
            if (up_if.rdy !== exp_rdy) begin bad++; $display("FAIL rand_irdy cyc=%0d got=%b want=%b", i, up_if.rdy, exp_rdy); end
            if (exp_vld) begin
                total++;
                if (dn_if.dat !== mq[0]) begin bad++; $display("FAIL rand_dat cyc=%0d got=%h want=%h", i, dn_if.dat, mq[0]); end
            end
            if (stall) begin
                total++;
                if (dn_if.dat !== held) begin bad++; $display("FAIL rand_stable cyc=%0d got=%h want=%h", i, dn_if.dat, held); end
            end
            total++;
            if (dn_if.vld === 1'b0 && up_if.rdy === 1'b0) begin bad++; $display("FAIL rand_illegal cyc=%0d got state=10 want legal", i); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        total++;
        if (dn_if.vld !== 1'b0 || up_if.rdy !== 1'b1) begin
            bad++; $display("FAIL rand_drain got vld=%b irdy=%b want vld=0 irdy=1", dn_if.vld, up_if.rdy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_streaming();
        test_skid();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
